// File: rtl/fan_pwm_tach.sv
// N-channel fan controller: shadowed PWM, filtered tach count per window, stall IRQ.
// Bus: one ACK per access, one cycle after STB, read data registered; never stalls.
module fan_pwm_tach #(
  parameter int NCH       = 4,
  parameter int PWM_W     = 10,
  parameter int CNT_W     = 27,
  parameter int WIN_CNT   = 50000000,
  parameter int FILT      = 8,
  parameter int STALL_WIN = 3
) (
  input  logic             CLK_I,
  input  logic             RST_N_I,
  input  logic             FAN_STB_I,
  input  logic             FAN_WE_I,
  input  logic [5:0]       FAN_ADR_I,
  input  logic [31:0]      FAN_DAT_I,
  output logic             FAN_ACK_O,
  output logic             FAN_ERR_O,
  output logic             FAN_RTY_O,
  output logic [31:0]      FAN_DAT_O,
  output logic [NCH-1:0]   PWM_O,
  input  logic [NCH-1:0]   TACH_I,
  output logic             FAN_INT_O
);

  localparam int              FC_W      = $clog2(FILT) + 1;
  localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILT - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CNT - 1);
  localparam logic [1:0]      STALL_CMP = 2'(STALL_WIN);

  logic [PWM_W-1:0] pwm_cnt;
  logic [CNT_W-1:0] win_cnt;
  logic             win_tc;
  logic             acc;

  logic [PWM_W-1:0] duty_q   [NCH];
  logic [PWM_W-1:0] shadow_q [NCH];
  logic [FC_W-1:0]  fcnt_q   [NCH];
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] tach_q   [NCH];
  logic [1:0]       zwin_q   [NCH];
  logic [1:0]       zwin_inc [NCH];

  logic [NCH-1:0] en_q, mask_q, inv_q, stall_q;
  logic [NCH-1:0] sync1_q, sync2_q, filt_q;
  logic [NCH-1:0] fall, stall_set, wr_ch, irq_vec;
  logic [31:0]    rd_dat;
  logic           unused_dat;

  assign acc        = FAN_STB_I & ~FAN_ACK_O;
  assign win_tc     = (win_cnt == WIN_LAST);
  assign irq_vec    = stall_q & ~mask_q;
  assign FAN_INT_O  = |irq_vec;
  assign FAN_ERR_O  = 1'b0;
  assign FAN_RTY_O  = 1'b0;
  assign unused_dat = ^FAN_DAT_I;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wr_ch[c]     = acc & FAN_WE_I & (FAN_ADR_I[5:2] == 4'(c));
      fall[c]      = filt_q[c] & ~sync2_q[c] & (fcnt_q[c] == FILT_LAST);
      zwin_inc[c]  = (zwin_q[c] == 2'd3) ? 2'd3 : zwin_q[c] + 2'd1;
      // Stall is raised at the window end that brings the zero-window count to the threshold.
      stall_set[c] = win_tc & (cnt_q[c] == '0) & (zwin_inc[c] == STALL_CMP);
      PWM_O[c]     = (en_q[c] & (pwm_cnt < shadow_q[c])) ^ inv_q[c];
    end
  end

  always_comb begin
    rd_dat = '0;
    if (FAN_ADR_I == 6'h3F) rd_dat[NCH-1:0] = irq_vec;
    for (int c = 0; c < NCH; c++) begin
      if (FAN_ADR_I[5:2] == 4'(c)) begin
        case (FAN_ADR_I[1:0])
          2'd0: rd_dat[PWM_W-1:0] = duty_q[c];
          2'd1: rd_dat[CNT_W-1:0] = tach_q[c];
          2'd2: rd_dat[2:0]       = {inv_q[c], mask_q[c], en_q[c]};
          default: begin
            rd_dat[9:8] = zwin_q[c];
            rd_dat[0]   = stall_q[c];
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      FAN_ACK_O <= 1'b0;
      FAN_DAT_O <= '0;
      pwm_cnt   <= '0;
      win_cnt   <= '0;
      en_q      <= '0;
      mask_q    <= '1;
      inv_q     <= '0;
      stall_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      for (int c = 0; c < NCH; c++) begin
        duty_q[c]   <= '0;
        shadow_q[c] <= '0;
        fcnt_q[c]   <= '0;
        cnt_q[c]    <= '0;
        tach_q[c]   <= '0;
        zwin_q[c]   <= '0;
      end
    end else begin
      FAN_ACK_O <= acc;
      if (acc && !FAN_WE_I) FAN_DAT_O <= rd_dat;
      pwm_cnt <= pwm_cnt + 1'b1;
      win_cnt <= win_tc ? '0 : win_cnt + 1'b1;
      sync1_q <= TACH_I;
      sync2_q <= sync1_q;

      for (int c = 0; c < NCH; c++) begin
        if (sync2_q[c] != filt_q[c]) begin
          if (fcnt_q[c] == FILT_LAST) begin
            filt_q[c] <= sync2_q[c];
            fcnt_q[c] <= '0;
          end else begin
            fcnt_q[c] <= fcnt_q[c] + 1'b1;
          end
        end else begin
          fcnt_q[c] <= '0;
        end

        // Shadow samples the old DUTY, so a write in the wrap cycle waits a full period.
        if (pwm_cnt == '0) shadow_q[c] <= duty_q[c];

        if (win_tc) begin
          tach_q[c] <= cnt_q[c];
          cnt_q[c]  <= fall[c] ? CNT_W'(1) : '0;
          zwin_q[c] <= (cnt_q[c] == '0) ? zwin_inc[c] : 2'd0;
        end else if (fall[c] && (cnt_q[c] != '1)) begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end

        if (wr_ch[c]) begin
          case (FAN_ADR_I[1:0])
            2'd0: duty_q[c] <= FAN_DAT_I[PWM_W-1:0];
            2'd2: begin
              en_q[c]   <= FAN_DAT_I[0];
              mask_q[c] <= FAN_DAT_I[1];
              inv_q[c]  <= FAN_DAT_I[2];
            end
            2'd3: if (FAN_DAT_I[0]) stall_q[c] <= 1'b0;
            default: ;
          endcase
        end
        if (stall_set[c]) stall_q[c] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fan_pwm_tach.sv
// Directed bench for fan_pwm_tach: register table, PWM shapes, tach windows, stall/IRQ corners.
module tb_fan_pwm_tach;
  localparam int NCH = 4;
  localparam int PWM_W = 4;
  localparam int CNT_W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           stb = 1'b0;
  logic           we = 1'b0;
  logic [5:0]     adr = '0;
  logic [31:0]    wdat = '0;
  logic           ack, err, rty, irq;
  logic [31:0]    rdat;
  logic [NCH-1:0] pwm;
  logic [NCH-1:0] tach;
  logic           t0 = 1'b0, t1 = 1'b0, t2 = 1'b0, t3 = 1'b0;

  assign tach = {t3, t2, t1, t0};

  fan_pwm_tach #(.NCH(NCH), .PWM_W(PWM_W), .CNT_W(CNT_W), .WIN_CNT(1000),
                 .FILT(8), .STALL_WIN(3)) dut (
    .CLK_I(clk), .RST_N_I(rst_n), .FAN_STB_I(stb), .FAN_WE_I(we),
    .FAN_ADR_I(adr), .FAN_DAT_I(wdat), .FAN_ACK_O(ack), .FAN_ERR_O(err),
    .FAN_RTY_O(rty), .FAN_DAT_O(rdat), .PWM_O(pwm), .TACH_I(tach),
    .FAN_INT_O(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nfail = 0;
  int tmode = 0;
  int pc = 0;

  // Tach stimulus for channel 1: 0 idle, 1 square wave of period 20, 2 three-cycle pulses.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (tmode)
        1: begin
          pc++;
          if (pc >= 10) begin t1 = ~t1; pc = 0; end
        end
        2: begin
          t1 = (pc < 3);
          pc = (pc >= 19) ? 0 : pc + 1;
        end
        default: begin t1 = 1'b0; pc = 0; end
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input logic [31:0] act, input int lo, input int hi);
    nvec++;
    if ((act < 32'(lo)) || (act > 32'(hi))) begin
      nfail++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic bus(input logic w, input logic [5:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic ack_ok, output logic irq_at_ack);
    @(negedge clk);
    stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    ack_ok = ack;
    rd = rdat;
    irq_at_ack = irq;
    @(posedge clk); #1;
    ack_ok = ack_ok & ~ack;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(output int r0);
    @(negedge clk);
    rst_n = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = cyc + 1;
  endtask

  task automatic count_hi(input int n, output int h);
    h = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (pwm[0]) h++;
    end
  endtask

  typedef struct {
    logic        w;
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] rd;
  logic        ok, ia, prev;
  int          ha, hb, r0, r1, found;

  initial begin
    tbl[0]  = '{1'b0, 6'd2,  32'd0,        32'h2};
    tbl[1]  = '{1'b0, 6'd0,  32'd0,        32'h0};
    tbl[2]  = '{1'b0, 6'd14, 32'd0,        32'h2};
    tbl[3]  = '{1'b0, 6'd1,  32'd0,        32'h0};
    tbl[4]  = '{1'b0, 6'd3,  32'd0,        32'h0};
    tbl[5]  = '{1'b1, 6'd4,  32'h1A5,      32'h0};
    tbl[6]  = '{1'b0, 6'd4,  32'd0,        32'h5};
    tbl[7]  = '{1'b1, 6'd10, 32'h3,        32'h0};
    tbl[8]  = '{1'b0, 6'd10, 32'd0,        32'h3};
    tbl[9]  = '{1'b1, 6'd10, 32'hFFFFFFFA, 32'h0};
    tbl[10] = '{1'b0, 6'd10, 32'd0,        32'h2};
    tbl[11] = '{1'b1, 6'h3F, 32'hFF,       32'h0};
    tbl[12] = '{1'b0, 6'h3F, 32'd0,        32'h0};
    tbl[13] = '{1'b1, 6'h21, 32'h5,        32'h0};
    tbl[14] = '{1'b0, 6'h21, 32'd0,        32'h0};
    tbl[15] = '{1'b0, 6'h3E, 32'd0,        32'h0};

    do_reset(r0);
    @(posedge clk); #1;
    chk("rst ack", 32'(ack), 32'd0);
    chk("rst dat", rdat, 32'd0);
    chk("rst pwm", 32'(pwm), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    chk("err const", 32'(err), 32'd0);
    chk("rty const", 32'(rty), 32'd0);

    for (int i = 0; i < 16; i++) begin
      bus(tbl[i].w, tbl[i].a, tbl[i].d, rd, ok, ia);
      chk($sformatf("vec%0d ack", i), 32'(ok), 32'd1);
      if (!tbl[i].w) chk($sformatf("vec%0d rdat", i), rd, tbl[i].exp);
      chk($sformatf("vec%0d pwm", i), 32'(pwm), 32'd0);
      chk($sformatf("vec%0d irq", i), 32'(ia), 32'd0);
    end

    // PWM shapes on channel 0.
    bus(1'b1, 6'd0, 32'd5, rd, ok, ia);
    bus(1'b1, 6'd2, 32'h3, rd, ok, ia);
    repeat (40) @(posedge clk); #1;
    count_hi(16, ha);
    chk("pwm duty5", 32'(ha), 32'd5);
    bus(1'b1, 6'd2, 32'h7, rd, ok, ia);
    repeat (40) @(posedge clk); #1;
    count_hi(16, ha);
    chk("pwm duty5 inv", 32'(ha), 32'd11);
    bus(1'b1, 6'd2, 32'h3, rd, ok, ia);
    bus(1'b1, 6'd0, 32'd15, rd, ok, ia);
    repeat (40) @(posedge clk); #1;
    count_hi(16, ha);
    chk("pwm duty max", 32'(ha), 32'd15);
    bus(1'b1, 6'd0, 32'd0, rd, ok, ia);
    repeat (40) @(posedge clk); #1;
    count_hi(16, ha);
    chk("pwm duty0", 32'(ha), 32'd0);
    bus(1'b1, 6'd0, 32'd5, rd, ok, ia);
    repeat (40) @(posedge clk); #1;

    // Find the wrap (rising PWM edge = counter at 0), then write DUTY in that cycle.
    found = 0;
    prev = pwm[0];
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(posedge clk); #1;
      if (!prev && pwm[0]) found = 1;
      else prev = pwm[0];
    end
    chk("pwm wrap found", 32'(found), 32'd1);
    fork
      begin
        ha = 0; hb = 0;
        for (int i = 0; i < 32; i++) begin
          if (pwm[0]) begin
            if (i < 16) ha++;
            else hb++;
          end
          @(posedge clk); #1;
        end
      end
      bus(1'b1, 6'd0, 32'd9, rd, ok, ia);
    join
    chk("duty at wrap, same period", 32'(ha), 32'd5);
    chk("duty at wrap, next period", 32'(hb), 32'd9);

    // Tach windows and stall detection, timed from reset release.
    tmode = 1; t3 = 1'b1; t0 = 1'b0; t2 = 1'b0;
    do_reset(r0);
    wait_until(r0 + 2);
    bus(1'b1, 6'd10, 32'h0, rd, ok, ia);
    wait_until(r0 + 1200);
    bus(1'b0, 6'd5, 32'd0, rd, ok, ia);
    chk_rng("tach1 square w1", rd, 49, 51);
    wait_until(r0 + 1989);
    t3 = 1'b0;
    wait_until(r0 + 2100);
    bus(1'b0, 6'd13, 32'd0, rd, ok, ia);
    chk("tach3 excludes tc edge", rd, 32'd0);
    bus(1'b0, 6'd5, 32'd0, rd, ok, ia);
    chk_rng("tach1 square w2", rd, 49, 51);
    wait_until(r0 + 2998);
    chk("irq before stall", 32'(irq), 32'd0);
    wait_until(r0 + 2999);
    chk("irq at stall", 32'(irq), 32'd1);
    bus(1'b0, 6'h3F, 32'd0, rd, ok, ia);
    chk("irq reg", rd, 32'h4);
    bus(1'b0, 6'd11, 32'd0, rd, ok, ia);
    chk("stat2 stalled", rd, 32'h301);
    wait_until(r0 + 3100);
    bus(1'b1, 6'd11, 32'h1, rd, ok, ia);
    chk("irq after w1c", 32'(ia), 32'd0);
    bus(1'b0, 6'd11, 32'd0, rd, ok, ia);
    chk("stat2 cleared", rd, 32'h300);
    bus(1'b0, 6'd13, 32'd0, rd, ok, ia);
    chk("tach3 new window has edge", rd, 32'd1);
    wait_until(r0 + 3200);
    tmode = 2;
    wait_until(r0 + 3998);
    bus(1'b1, 6'd11, 32'h1, rd, ok, ia);
    chk("irq w1c vs set", 32'(ia), 32'd1);
    bus(1'b0, 6'd11, 32'd0, rd, ok, ia);
    chk("stat2 set wins", rd, 32'h301);
    wait_until(r0 + 5100);
    bus(1'b0, 6'd5, 32'd0, rd, ok, ia);
    chk("tach1 short pulses", rd, 32'd0);

    // Reset in the middle of a window.
    tmode = 1;
    wait_until(r0 + 5600);
    do_reset(r1);
    wait_until(r1 + 3);
    bus(1'b0, 6'd5, 32'd0, rd, ok, ia);
    chk("tach1 after reset", rd, 32'd0);
    chk("irq after reset", 32'(ia), 32'd0);
    bus(1'b0, 6'd11, 32'd0, rd, ok, ia);
    chk("stat2 after reset", rd, 32'h0);
    bus(1'b0, 6'd10, 32'd0, rd, ok, ia);
    chk("cfg2 after reset", rd, 32'h2);
    wait_until(r1 + 998);
    bus(1'b0, 6'd5, 32'd0, rd, ok, ia);
    chk("tach1 before restarted tc", rd, 32'd0);
    bus(1'b0, 6'd5, 32'd0, rd, ok, ia);
    chk_rng("tach1 restarted window", rd, 49, 51);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
